// File: rtl/riscv_core_icache_pkg.sv
// Shared types and AXI constants for the I-cache refill path.
package riscv_core_icache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StR,
        StWr,
        StDone
    } refill_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int unsigned LINE_BYTES = 32;
    localparam int unsigned BEATS      = LINE_BYTES * 8 / 64;

endpackage

// File: rtl/riscv_core_icache_refill.sv
// I-cache refill engine: fetches one or two lines over AXI4 INCR bursts and
// writes each assembled line into the I-cache data array.
module riscv_core_icache_refill
    import riscv_core_icache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned LINE_WIDTH     = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_miss_req,
    input  logic [ADDR_WIDTH-1:0]     i_miss_addr,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_err,
    output logic [LINE_WIDTH-1:0]     o_block,
    output logic                      o_wr_en,
    output logic                      o_block_replace,
    output logic                      o_offset,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic                      i_rvalid,
    output logic                      o_rready
);

    localparam int unsigned NumBeats = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int unsigned CntW     = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int unsigned LineLsb  = $clog2(LINE_WIDTH / 8);
    localparam int unsigned LineIdxW = ADDR_WIDTH - LineLsb;
    localparam logic [7:0]  ArLen    = 8'(NumBeats - 1);
    localparam logic [2:0]  ArSize   = 3'($clog2(AXI_DATA_WIDTH / 8));

    refill_state_e          state_q, state_d;
    logic                   cross_q, cross_d;
    logic                   line_sel_q, line_sel_d;
    logic                   err_q, err_d;
    logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [LINE_WIDTH-1:0]  block_q;
    logic                   beat_fire;
    logic                   last_beat;
    logic                   cross_now;
    logic [LineIdxW-1:0]    line_idx;
    logic                   unused_addr_bit0;

    // addr+2 leaves the line exactly when the halfword index is at its top.
    assign cross_now        = &i_miss_addr[LineLsb-1:1];
    assign unused_addr_bit0 = i_miss_addr[0];
    assign line_idx         = i_miss_addr[ADDR_WIDTH-1:LineLsb] + LineIdxW'(line_sel_q);
    assign last_beat        = (beat_cnt_q == CntW'(NumBeats - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            cross_q    <= 1'b0;
            line_sel_q <= 1'b0;
            err_q      <= 1'b0;
            beat_cnt_q <= '0;
            block_q    <= '0;
        end else begin
            state_q    <= state_d;
            cross_q    <= cross_d;
            line_sel_q <= line_sel_d;
            err_q      <= err_d;
            beat_cnt_q <= beat_cnt_d;
            if (beat_fire) begin
                block_q[beat_cnt_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        cross_d         = cross_q;
        line_sel_d      = line_sel_q;
        err_d           = err_q;
        beat_cnt_d      = beat_cnt_q;
        beat_fire       = 1'b0;
        o_done          = 1'b0;
        o_err           = 1'b0;
        o_wr_en         = 1'b0;
        o_block_replace = 1'b0;
        o_offset        = 1'b0;
        o_araddr        = '0;
        o_arlen         = '0;
        o_arsize        = '0;
        o_arburst       = '0;
        o_arvalid       = 1'b0;
        o_rready        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_miss_req) begin
                    state_d    = StAr;
                    cross_d    = cross_now;
                    line_sel_d = 1'b0;
                    err_d      = 1'b0;
                    beat_cnt_d = '0;
                end
            end
            StAr: begin
                o_arvalid = 1'b1;
                o_araddr  = {line_idx, {LineLsb{1'b0}}};
                o_arlen   = ArLen;
                o_arsize  = ArSize;
                o_arburst = AXI_BURST_INCR;
                if (i_arready) begin
                    state_d = StR;
                end
            end
            StR: begin
                o_rready = 1'b1;
                if (i_rvalid) begin
                    beat_fire  = 1'b1;
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                    // The beat count alone ends the line; RLAST is only cross-checked.
                    if (i_rresp != AXI_RESP_OKAY || i_rlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = StWr;
                    end
                end
            end
            StWr: begin
                o_wr_en         = !err_q;
                o_block_replace = !err_q;
                o_offset        = line_sel_q;
                if (cross_q && !line_sel_q && !err_q) begin
                    line_sel_d = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = StAr;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                o_done  = 1'b1;
                o_err   = err_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_busy  = (state_q != StIdle);
    assign o_block = block_q;

endmodule

// File: tb/tb_riscv_core_icache_refill.sv
// Scoreboard bench for the I-cache refill engine: stimulus pushes expected
// AR/WR/DONE events, a negedge monitor pops and compares them.
module tb_riscv_core_icache_refill;
    import riscv_core_icache_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_miss_req;
    logic [63:0]  i_miss_addr;
    logic         o_busy, o_done, o_err;
    logic [255:0] o_block;
    logic         o_wr_en, o_block_replace, o_offset;
    logic [63:0]  o_araddr;
    logic [7:0]   o_arlen;
    logic [2:0]   o_arsize;
    logic [1:0]   o_arburst;
    logic         o_arvalid, i_arready;
    logic [63:0]  i_rdata;
    logic [1:0]   i_rresp;
    logic         i_rlast, i_rvalid, o_rready;

    riscv_core_icache_refill dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_miss_req(i_miss_req), .i_miss_addr(i_miss_addr),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_block(o_block),
        .o_wr_en(o_wr_en), .o_block_replace(o_block_replace), .o_offset(o_offset),
        .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .i_rdata(i_rdata), .i_rresp(i_rresp),
        .i_rlast(i_rlast), .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct { logic [255:0] blk; logic off; int cyc; } wr_exp_t;
    typedef struct { logic err; int cyc; } done_exp_t;

    logic [63:0] ar_q[$];
    wr_exp_t     wr_q[$];
    done_exp_t   done_q[$];

    logic        prev_arwait = 1'b0;
    logic [63:0] prev_araddr = '0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bad_event(input string name);
        checks++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Monitor
    always @(negedge i_clk) begin
        if (i_rst) begin
            prev_arwait = 1'b0;
        end else begin
            if (prev_arwait) begin
                chk("arvalid_hold", 256'(o_arvalid), 256'(1));
                chk("araddr_hold", 256'(o_araddr), 256'(prev_araddr));
            end
            prev_arwait = o_arvalid && !i_arready;
            prev_araddr = o_araddr;
            if (o_arvalid && i_arready) begin
                if (ar_q.size() == 0) begin
                    bad_event("unexpected_ar");
                end else begin
                    logic [63:0] ea;
                    ea = ar_q.pop_front();
                    chk("araddr", 256'(o_araddr), 256'(ea));
                    chk("arlen", 256'(o_arlen), 256'(3));
                    chk("arsize", 256'(o_arsize), 256'(3));
                    chk("arburst", 256'(o_arburst), 256'(AXI_BURST_INCR));
                end
            end
            if (o_wr_en) begin
                if (wr_q.size() == 0) begin
                    bad_event("unexpected_wr");
                end else begin
                    wr_exp_t ew;
                    ew = wr_q.pop_front();
                    chk("wr_block", o_block, ew.blk);
                    chk("wr_offset", 256'(o_offset), 256'(ew.off));
                    chk("wr_replace", 256'(o_block_replace), 256'(1));
                    if (ew.cyc >= 0) chk("wr_cycle", 256'(cyc), 256'(ew.cyc));
                end
            end
            if (o_done) begin
                if (done_q.size() == 0) begin
                    bad_event("unexpected_done");
                end else begin
                    done_exp_t ed;
                    ed = done_q.pop_front();
                    chk("done_err", 256'(o_err), 256'(ed.err));
                    if (ed.cyc >= 0) chk("done_cycle", 256'(cyc), 256'(ed.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic req(input logic [63:0] a, output int c);
        i_miss_addr = a;
        i_miss_req  = 1'b1;
        c           = cyc;
        tick();
        i_miss_req  = 1'b0;
    endtask

    task automatic ar_accept(input int delay, input bit junk_r);
        int t = 0;
        while (!o_arvalid) begin
            if (t == 50) begin
                checks++;
                $display("FAIL ar_wait: got timeout expected arvalid");
                return;
            end
            tick();
            t++;
        end
        if (junk_r) begin
            i_rvalid = 1'b1;
            i_rdata  = 64'hDEADDEADDEADDEAD;
        end
        repeat (delay) tick();
        i_rvalid  = 1'b0;
        i_arready = 1'b1;
        tick();
        i_arready = 1'b0;
    endtask

    task automatic beats(input logic [255:0] blk, input logic [7:0] resp, input logic [3:0] last,
                         input logic [15:0] gap, input int n);
        for (int k = 0; k < n; k++) begin
            repeat (int'(gap[4*k +: 4])) tick();
            i_rvalid = 1'b1;
            i_rdata  = blk[64*k +: 64];
            i_rresp  = resp[2*k +: 2];
            i_rlast  = last[k];
            tick();
            i_rvalid = 1'b0;
            i_rlast  = 1'b0;
            i_rresp  = AXI_RESP_OKAY;
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (o_busy && t < 100) begin
            tick();
            t++;
        end
        if (o_busy) begin
            checks++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
        repeat (3) tick();
        chk({name, "_ar_left"}, 256'(ar_q.size()), 256'(0));
        chk({name, "_wr_left"}, 256'(wr_q.size()), 256'(0));
        chk({name, "_done_left"}, 256'(done_q.size()), 256'(0));
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, 256'(o_busy), 256'(0));
        chk({name, "_done"}, 256'(o_done), 256'(0));
        chk({name, "_err"}, 256'(o_err), 256'(0));
        chk({name, "_block"}, o_block, 256'(0));
        chk({name, "_wr_en"}, 256'({o_wr_en, o_block_replace, o_offset}), 256'(0));
        chk({name, "_ar"}, 256'({o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst}), 256'(0));
        chk({name, "_rready"}, 256'(o_rready), 256'(0));
    endtask

    localparam logic [255:0] Blk1 = {64'h4444444444444444, 64'h3333333333333333,
                                     64'h2222222222222222, 64'h1111111111111111};
    localparam logic [255:0] BlkA = {64'hA3A3A3A3A3A3A3A3, 64'hA2A2A2A2A2A2A2A2,
                                     64'hA1A1A1A1A1A1A1A1, 64'hA0A0A0A0A0A0A0A0};
    localparam logic [255:0] BlkB = {64'hB3B3B3B3B3B3B3B3, 64'hB2B2B2B2B2B2B2B2,
                                     64'hB1B1B1B1B1B1B1B1, 64'hB0B0B0B0B0B0B0B0};
    localparam logic [255:0] BlkC = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                                     64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0};

    initial begin
        int c;
        i_rst       = 1'b1;
        i_miss_req  = 1'b0;
        i_miss_addr = '0;
        i_arready   = 1'b0;
        i_rdata     = '0;
        i_rresp     = AXI_RESP_OKAY;
        i_rlast     = 1'b0;
        i_rvalid    = 1'b0;
        repeat (2) tick();
        i_rst = 1'b0;
        chk_zero("reset");

        // Single line, zero wait states
        ar_q.push_back(64'h1000);
        req(64'h1000, c);
        wr_q.push_back('{blk: Blk1, off: 1'b0, cyc: c + 6});
        done_q.push_back('{err: 1'b0, cyc: c + 7});
        ar_accept(0, 1'b0);
        beats(Blk1, 8'h00, 4'b1000, 16'h0000, 4);
        wait_idle("single");
        chk("block_hold", o_block, Blk1);

        // Line-crossing fetch: two bursts, two writes, one done
        ar_q.push_back(64'h1000);
        ar_q.push_back(64'h1020);
        req(64'h101E, c);
        wr_q.push_back('{blk: BlkA, off: 1'b0, cyc: c + 6});
        wr_q.push_back('{blk: BlkB, off: 1'b1, cyc: c + 12});
        done_q.push_back('{err: 1'b0, cyc: c + 13});
        ar_accept(0, 1'b0);
        beats(BlkA, 8'h00, 4'b1000, 16'h0000, 4);
        ar_accept(0, 1'b0);
        beats(BlkB, 8'h00, 4'b1000, 16'h0000, 4);
        wait_idle("cross");

        // Backpressure on AR, stray RVALID while in AR, gaps between beats
        ar_q.push_back(64'h2000);
        req(64'h2008, c);
        wr_q.push_back('{blk: BlkC, off: 1'b0, cyc: -1});
        done_q.push_back('{err: 1'b0, cyc: -1});
        ar_accept(3, 1'b1);
        beats(BlkC, 8'h00, 4'b1000, 16'h1201, 4);
        wait_idle("backpressure");

        // SLVERR on beat 2 of a crossing fetch: no write, no second AR
        ar_q.push_back(64'h3020);
        req(64'h303E, c);
        done_q.push_back('{err: 1'b1, cyc: -1});
        ar_accept(0, 1'b0);
        beats(BlkA, 8'h20, 4'b1000, 16'h0000, 4);
        wait_idle("slverr");

        // Early RLAST on beat 1
        ar_q.push_back(64'h4000);
        req(64'h4000, c);
        done_q.push_back('{err: 1'b1, cyc: -1});
        ar_accept(0, 1'b0);
        beats(BlkB, 8'h00, 4'b1010, 16'h0000, 4);
        wait_idle("rlast");

        // Reset mid-burst after three beats
        ar_q.push_back(64'h5000);
        req(64'h5000, c);
        ar_accept(0, 1'b0);
        beats(BlkA, 8'h00, 4'b0000, 16'h0000, 3);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk_zero("midreset");

        // Normal fetch after the reset
        ar_q.push_back(64'h6000);
        req(64'h6004, c);
        wr_q.push_back('{blk: Blk1, off: 1'b0, cyc: c + 6});
        done_q.push_back('{err: 1'b0, cyc: c + 7});
        ar_accept(0, 1'b0);
        beats(Blk1, 8'h00, 4'b1000, 16'h0000, 4);
        wait_idle("after_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
